// File: rtl/cp0_irq_unit.sv
// CP0 exception/interrupt unit (M stage): SR/Cause/EPC/PRId, NUM_HWINT level-sensitive interrupt lines.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_irq_unit #(
  parameter int unsigned NUM_HWINT    = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h2023_0007
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [31:0]          victim_pc,
  input  logic                 bd,
  input  logic [4:0]           exc_code,
  input  logic                 eret,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic                 req,
  output logic [31:0]          handler_pc,
  output logic [31:0]          epc_out
);

  logic                 ie_q, ie_d;
  logic                 exl_q, exl_d;
  logic [NUM_HWINT-1:0] im_q, im_d;
  logic                 bd_q, bd_d;
  logic [NUM_HWINT-1:0] ip_q, ip_d;
  logic [4:0]           exccode_q, exccode_d;
  logic [29:0]          epc_q, epc_d;

  logic [NUM_HWINT-1:0] hwint_eff;
  logic                 int_req;
  logic                 exc_req;
  logic                 wr;
  logic [31:0]          victim_al;
  logic [31:0]          sr_rd;
  logic [31:0]          cause_rd;
  logic                 unused_victim_lo;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        ti_eff;
`endif

  assign unused_victim_lo = ^victim_pc[1:0];
  assign victim_al        = {victim_pc[31:2], 2'b00};
  assign handler_pc       = HANDLER_ADDR;
  assign epc_out          = {epc_q, 2'b00};

  always_comb begin
    hwint_eff = hwint;
`ifdef CP0_TIMER_EN
    // Match is seen combinationally so the interrupt fires in the cycle Count reaches Compare.
    ti_eff = ti_q | ((count_q == compare_q) && (compare_q != '0));
    hwint_eff[NUM_HWINT-1] = hwint[NUM_HWINT-1] | ti_eff;
`endif
    int_req = (|(hwint_eff & im_q)) & ie_q & ~exl_q;
    exc_req = (exc_code != '0) & ~exl_q;
    req     = int_req | exc_req;
    wr      = we & ~req;
  end

  always_comb begin
    ie_d      = ie_q;
    exl_d     = exl_q;
    im_d      = im_q;
    bd_d      = bd_q;
    ip_d      = hwint_eff;
    exccode_d = exccode_q;
    epc_d     = epc_q;
`ifdef CP0_TIMER_EN
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    ti_d      = ti_eff;
`endif
    if (req) begin
      exl_d     = 1'b1;
      exccode_d = int_req ? 5'd0 : exc_code;
      bd_d      = bd;
      epc_d     = bd ? ((victim_al - 32'd4) >> 2) : victim_al[31:2];
    end else begin
      if (wr) begin
        case (addr)
          5'd12: begin
            ie_d  = wdata[0];
            exl_d = wdata[1];
            im_d  = wdata[10 +: NUM_HWINT];
          end
          5'd14: epc_d = wdata[31:2];
`ifdef CP0_TIMER_EN
          5'd9:  count_d = wdata;
          5'd11: begin
            compare_d = wdata;
            ti_d      = 1'b0;
          end
`endif
          default: ;
        endcase
      end
      // eret runs after the SR write so its EXL clear wins.
      if (eret) exl_d = 1'b0;
    end
  end

  always_comb begin
    sr_rd                    = '0;
    sr_rd[0]                 = ie_q;
    sr_rd[1]                 = exl_q;
    sr_rd[10 +: NUM_HWINT]   = im_q;
    cause_rd                 = '0;
    cause_rd[31]             = bd_q;
    cause_rd[10 +: NUM_HWINT] = ip_q;
    cause_rd[6:2]            = exccode_q;
    case (addr)
      5'd12:   rdata = sr_rd;
      5'd13:   rdata = cause_rd;
      5'd14:   rdata = {epc_q, 2'b00};
      5'd15:   rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
      5'd9:    rdata = count_q;
      5'd11:   rdata = compare_q;
`endif
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      im_q      <= '0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
`ifdef CP0_TIMER_EN
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
`endif
    end else begin
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      im_q      <= im_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
`ifdef CP0_TIMER_EN
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
`endif
    end
  end

endmodule
